// File: rtl/lpc_capture_ctrl_if.sv
// rtl/lpc_capture_ctrl_if.sv - decoder, config and byte-stream signals of the capture controller
interface lpc_capture_ctrl_if #(
  parameter int CW = 4
);
  logic [3:0]    in_cyctype_dir;
  logic [31:0]   in_addr;
  logic [7:0]    in_data;
  logic          in_latch;
  logic          cfg_enable;
  logic [15:0]   cfg_addr_match;
  logic [15:0]   cfg_addr_mask;
  logic [7:0]    out_byte;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] fifo_count;
  logic [7:0]    drop_count;
  logic          busy;

  modport master (
    output in_cyctype_dir, in_addr, in_data, in_latch,
    output cfg_enable, cfg_addr_match, cfg_addr_mask, out_ready,
    input  out_byte, out_valid, fifo_count, drop_count, busy
  );

  modport slave (
    input  in_cyctype_dir, in_addr, in_data, in_latch,
    input  cfg_enable, cfg_addr_match, cfg_addr_mask, out_ready,
    output out_byte, out_valid, fifo_count, drop_count, busy
  );
endinterface

// File: rtl/lpc_capture_ctrl.sv
// rtl/lpc_capture_ctrl.sv - filters decoded LPC transactions, queues them and streams 4-byte frames
module lpc_capture_ctrl #(
  parameter int DEPTH = 8,
  parameter int CW    = 4
) (
  input  logic lpc_clock,
  input  logic lpc_reset,
  lpc_capture_ctrl_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  // Entry layout: {ovf[28], cyctype_dir[27:24], addr[23:8], data[7:0]}
  logic [28:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          latch_prev_q, latch_prev_d;
  logic          drop_flag_q, drop_flag_d;
  logic [7:0]    drop_count_q, drop_count_d;
  state_t        state_q, state_d;
  logic [28:0]   frame_q, frame_d;
  logic [1:0]    idx_q, idx_d;

  logic        evt, hit, xfer, last, pop, push, drop;
  logic [28:0] push_data;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^bus.in_addr[31:16];

  // Event detection, address filter and FIFO push/pop decisions
  always_comb begin
    evt       = bus.in_latch & ~latch_prev_q;
    hit       = bus.cfg_enable &
                (((bus.in_addr[15:0] ^ bus.cfg_addr_match) & bus.cfg_addr_mask) == 16'h0000);
    xfer      = (state_q == SEND) & bus.out_ready;
    last      = xfer & (idx_q == 2'd3);
    pop       = (count_q != '0) & ((state_q == IDLE) | last);
    // A full FIFO still accepts when the head leaves in the same cycle
    push      = evt & hit & ((count_q != CW'(DEPTH)) | pop);
    drop      = evt & hit & ~push;
    push_data = {drop_flag_q, bus.in_cyctype_dir, bus.in_addr[15:0], bus.in_data};
  end

  // FIFO bookkeeping and drop accounting
  always_comb begin
    latch_prev_d = bus.in_latch;
    wr_ptr_d     = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d     = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d      = count_q;
    if (push && !pop) count_d = count_q + CW'(1);
    if (pop && !push) count_d = count_q - CW'(1);
    drop_flag_d  = drop_flag_q;
    if (push) drop_flag_d = 1'b0;
    if (drop) drop_flag_d = 1'b1;
    drop_count_d = (drop && drop_count_q != 8'hFF) ? drop_count_q + 8'd1 : drop_count_q;
  end

  // Frame sequencer: load a frame on pop, walk four bytes, chain frames without gaps
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          frame_d = mem_q[rd_ptr_q];
          idx_d   = 2'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          if (last) begin
            idx_d = 2'd0;
            if (pop) frame_d = mem_q[rd_ptr_q];
            else     state_d = IDLE;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stream byte selected from the frame register; zero outside a frame
  always_comb begin
    bus.out_byte = 8'h00;
    if (state_q == SEND) begin
      case (idx_q)
        2'd0:    bus.out_byte = {frame_q[27:24], 3'b000, frame_q[28]};
        2'd1:    bus.out_byte = frame_q[23:16];
        2'd2:    bus.out_byte = frame_q[15:8];
        default: bus.out_byte = frame_q[7:0];
      endcase
    end
  end

  assign bus.out_valid  = (state_q == SEND);
  assign bus.fifo_count = count_q;
  assign bus.drop_count = drop_count_q;
  assign bus.busy       = (state_q == SEND) | (count_q != '0);

  // FIFO storage; contents need no reset since pointers define validity
  always_ff @(posedge lpc_clock) begin
    if (lpc_reset && push) mem_q[wr_ptr_q] <= push_data;
  end

  // State registers; latch_prev resets high so a latch held through reset does not capture
  always_ff @(posedge lpc_clock) begin
    if (!lpc_reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      latch_prev_q <= 1'b1;
      drop_flag_q  <= 1'b0;
      drop_count_q <= 8'h00;
      state_q      <= IDLE;
      frame_q      <= '0;
      idx_q        <= 2'd0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      latch_prev_q <= latch_prev_d;
      drop_flag_q  <= drop_flag_d;
      drop_count_q <= drop_count_d;
      state_q      <= state_d;
      frame_q      <= frame_d;
      idx_q        <= idx_d;
    end
  end
endmodule

// File: tb/tb_lpc_capture_ctrl.sv
// tb/tb_lpc_capture_ctrl.sv - self-checking bench for lpc_capture_ctrl
module tb_lpc_capture_ctrl;
  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  lpc_capture_ctrl_if #(.CW(CW)) bus ();

  lpc_capture_ctrl #(.DEPTH(DEPTH), .CW(CW)) dut (
    .lpc_clock (clk),
    .lpc_reset (rstn),
    .bus       (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of pending entries plus the bytes of the frame on the wire
  logic [28:0] m_q[$];
  logic [7:0]  m_bytes[4];
  int          m_idx;
  bit          m_active;
  bit          m_prev;
  bit          m_flag;
  logic [7:0]  m_drop;
  logic [7:0]  cap[$];

  typedef struct {
    logic [15:0] addr;
    logic [15:0] match;
    logic [15:0] mask;
    logic        en;
    logic        exp_hit;
  } fvec_t;
  fvec_t ftab[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_active = 0;
    m_idx    = 0;
    m_prev   = 1;
    m_flag   = 0;
    m_drop   = 8'h00;
  endtask

  task automatic step();
    logic        evt, hit, xfer, last, pop;
    logic [28:0] ent;
    logic [21:0] act, exp;
    logic [7:0]  eb;
    if (rstn && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) cap.push_back(bus.out_byte);
    if (!rstn) begin
      model_reset();
    end else begin
      evt  = bus.in_latch && !m_prev;
      hit  = bus.cfg_enable && (((bus.in_addr[15:0] ^ bus.cfg_addr_match) & bus.cfg_addr_mask) == 16'h0);
      xfer = m_active && bus.out_ready;
      last = xfer && (m_idx == 3);
      pop  = (!m_active || last) && (m_q.size() > 0);
      if (xfer) m_idx++;
      if (last) m_active = 0;
      if (pop) begin
        ent        = m_q.pop_front();
        m_bytes[0] = {ent[27:24], 3'b000, ent[28]};
        m_bytes[1] = ent[23:16];
        m_bytes[2] = ent[15:8];
        m_bytes[3] = ent[7:0];
        m_active   = 1;
        m_idx      = 0;
      end
      if (evt && hit) begin
        if (m_q.size() < DEPTH) begin
          m_q.push_back({m_flag, bus.in_cyctype_dir, bus.in_addr[15:0], bus.in_data});
          m_flag = 0;
        end else begin
          m_flag = 1;
          if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
        end
      end
      m_prev = bus.in_latch;
    end
    @(posedge clk);
    #1;
    eb  = m_active ? m_bytes[m_idx] : 8'h00;
    act = {bus.out_valid, bus.out_byte, bus.fifo_count, bus.drop_count, bus.busy};
    exp = {m_active, eb, CW'(m_q.size()), m_drop, (m_active || m_q.size() != 0)};
    chk("cycle_model", {10'h0, act}, {10'h0, exp});
  endtask

  task automatic pulse(input logic [3:0] cyc, input logic [15:0] addr, input logic [7:0] data);
    bus.in_cyctype_dir = cyc;
    bus.in_addr        = {16'h0000, addr};
    bus.in_data        = data;
    bus.in_latch       = 1'b1;
    step();
    bus.in_latch       = 1'b0;
    step();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    step();
  endtask

  task automatic chk_frame(input string name, input int base, input logic [7:0] b0,
                           input logic [15:0] addr, input logic [7:0] data);
    logic [7:0] e[4];
    e[0] = b0; e[1] = addr[15:8]; e[2] = addr[7:0]; e[3] = data;
    for (int i = 0; i < 4; i++) begin
      if (base + i < cap.size()) chk(name, {24'h0, cap[base + i]}, {24'h0, e[i]});
      else chk(name, 32'hFFFF_FFFF, {24'h0, e[i]});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    bus.in_cyctype_dir = 4'h2;
    bus.in_addr        = 32'h0;
    bus.in_data        = 8'h00;
    bus.in_latch       = 1'b0;
    bus.cfg_enable     = 1'b1;
    bus.cfg_addr_match = 16'h0000;
    bus.cfg_addr_mask  = 16'h0000;
    bus.out_ready      = 1'b1;
    rstn               = 1'b0;
    model_reset();
    step();
    step();
    chk("reset_out_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("reset_out_byte", {24'h0, bus.out_byte}, 32'h0);
    chk("reset_fifo_count", {28'h0, bus.fifo_count}, 32'h0);
    chk("reset_drop_count", {24'h0, bus.drop_count}, 32'h0);
    chk("reset_busy", {31'h0, bus.busy}, 32'h0);
    rstn = 1'b1;
    step();

    // Single write: out_valid rises on the second edge after the latch edge
    cap.delete();
    bus.in_cyctype_dir = 4'h2;
    bus.in_addr        = 32'h0000_0080;
    bus.in_data        = 8'h5A;
    bus.in_latch       = 1'b1;
    step();
    chk("single_valid_k", {31'h0, bus.out_valid}, 32'h0);
    bus.in_latch = 1'b0;
    step();
    chk("single_valid_k1", {31'h0, bus.out_valid}, 32'h1);
    chk("single_byte0", {24'h0, bus.out_byte}, 32'h20);
    repeat (6) step();
    chk("single_len", cap.size(), 4);
    chk_frame("single_bytes", 0, 8'h20, 16'h0080, 8'h5A);
    chk("single_idle_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("single_idle_busy", {31'h0, bus.busy}, 32'h0);

    // Filter vectors
    ftab[0] = '{16'h0080, 16'h0080, 16'hFFFF, 1'b1, 1'b1};
    ftab[1] = '{16'h0081, 16'h0080, 16'hFFFF, 1'b1, 1'b0};
    ftab[2] = '{16'h1234, 16'h0000, 16'h0000, 1'b1, 1'b1};
    ftab[3] = '{16'h12F0, 16'h1200, 16'hFF00, 1'b1, 1'b1};
    ftab[4] = '{16'h13F0, 16'h1200, 16'hFF00, 1'b1, 1'b0};
    ftab[5] = '{16'h0080, 16'h0080, 16'hFFFF, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      cap.delete();
      bus.cfg_addr_match = ftab[i].match;
      bus.cfg_addr_mask  = ftab[i].mask;
      bus.cfg_enable     = ftab[i].en;
      pulse(4'h3, ftab[i].addr, 8'hA0 + 8'(i));
      repeat (6) step();
      chk($sformatf("filt_len_%0d", i), cap.size(), ftab[i].exp_hit ? 4 : 0);
      if (ftab[i].exp_hit) chk_frame($sformatf("filt_bytes_%0d", i), 0, 8'h30, ftab[i].addr, 8'hA0 + 8'(i));
      chk($sformatf("filt_drop_%0d", i), {24'h0, bus.drop_count}, 32'h0);
    end
    bus.cfg_enable     = 1'b1;
    bus.cfg_addr_match = 16'h0000;
    bus.cfg_addr_mask  = 16'h0000;

    // Backpressure after byte1 is presented
    cap.delete();
    pulse(4'h2, 16'h0080, 8'h5A);
    step();
    bus.out_ready = 1'b0;
    repeat (10) begin
      step();
      chk("bp_hold", {23'h0, bus.out_valid, bus.out_byte}, {23'h0, 1'b1, 8'h00});
    end
    bus.out_ready = 1'b1;
    repeat (6) step();
    chk_frame("bp_bytes", 0, 8'h20, 16'h0080, 8'h5A);

    // Overflow: frame register + 8 queued, the tenth event is dropped
    do_reset();
    cap.delete();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) pulse(4'h2, 16'h0080, 8'(i));
    chk("ovf_fifo_count", {28'h0, bus.fifo_count}, 32'd8);
    chk("ovf_drop_count", {24'h0, bus.drop_count}, 32'd1);
    bus.out_ready = 1'b1;
    repeat (4) step();
    pulse(4'h2, 16'h0080, 8'd10);
    repeat (50) step();
    chk("ovf_len", cap.size(), 40);
    for (int f = 0; f < 10; f++)
      chk_frame($sformatf("ovf_frame_%0d", f), 4 * f, (f == 9) ? 8'h21 : 8'h20,
                16'h0080, (f == 9) ? 8'd10 : 8'(f));

    // Latch held high across reset release
    bus.in_latch = 1'b1;
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
    repeat (6) step();
    chk("latch_rst_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("latch_rst_count", {28'h0, bus.fifo_count}, 32'h0);
    bus.in_latch = 1'b0;
    step();

    // Drop counter saturation
    bus.out_ready = 1'b0;
    for (int i = 0; i < 309; i++) pulse(4'h1, 16'h0100, 8'(i));
    chk("sat_drop_count", {24'h0, bus.drop_count}, 32'd255);
    chk("sat_fifo_count", {28'h0, bus.fifo_count}, 32'd8);

    // Reset mid-frame after byte1 transfers
    do_reset();
    bus.out_ready = 1'b1;
    pulse(4'h2, 16'h0080, 8'h77);
    step();
    step();
    rstn = 1'b0;
    step();
    chk("midrst_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("midrst_count", {28'h0, bus.fifo_count}, 32'h0);
    rstn = 1'b1;
    step();
    cap.delete();
    pulse(4'h2, 16'h0080, 8'h33);
    repeat (6) step();
    chk("midrst_len", cap.size(), 4);
    chk_frame("midrst_bytes", 0, 8'h20, 16'h0080, 8'h33);

    // Randomized traffic against the model
    bus.cfg_addr_match = 16'h0030;
    bus.cfg_addr_mask  = 16'h00F0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 2) == 0) bus.in_latch = ~bus.in_latch;
      bus.in_addr        = $urandom;
      if ($urandom_range(0, 1) == 0) bus.in_addr[7:4] = 4'h3;
      bus.in_data        = 8'($urandom);
      bus.in_cyctype_dir = 4'($urandom);
      bus.cfg_enable     = ($urandom_range(0, 9) != 0);
      bus.out_ready      = ($urandom_range(0, 9) < 6);
      rstn               = ($urandom_range(0, 499) != 0);
      step();
    end
    rstn = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lpc_capture_ctrl.md
Name: lpc_capture_ctrl

Overview:
- Sits downstream of the LPC decoder.
- Detects each completed transaction from the decoder's latch output and filters it by address match/mask.
- Queues accepted transactions in a small FIFO, then sequences each one out as a 4-byte frame over a valid/ready byte stream (to the UART/USB transmitter).
- Owns drop accounting when the host link cannot keep up with LPC traffic.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..64.
- CW, 4, width of fifo_count; must hold DEPTH, i.e. log2(DEPTH)+1.

Ports:
- lpc_clock  in  1  sole clock.
- lpc_reset  in  1  synchronous, active-low reset.
- in_cyctype_dir  in  4  cycle type/direction from decoder.
- in_addr  in  32  decoder address; only [15:0] used.
- in_data  in  8  decoder data byte.
- in_latch  in  1  decoder latch; a 0->1 transition marks a completed transaction.
- cfg_enable  in  1  capture enable.
- cfg_addr_match  in  16  address compare value.
- cfg_addr_mask  in  16  1 = bit compared.
- out_byte  out  8  stream byte.
- out_valid  out  1  out_byte valid.
- out_ready  in  1  sink accepts byte.
- fifo_count  out  CW  entries queued.
- drop_count  out  8  saturating count of dropped transactions.
- busy  out  1  frame in progress or FIFO non-empty.

Behaviour:
- Reset: only on a lpc_clock edge with lpc_reset=0.
  - Reset values: out_valid=0, out_byte=0, fifo_count=0, drop_count=0, busy=0.
  - FIFO pointers cleared, drop flag cleared, state=IDLE, latch_prev=1.
  - latch_prev=1 means an in_latch already high at reset release does not capture.
  - Reset mid-frame: the frame is abandoned, out_valid=0 the next cycle, no partial frame is resumed.
- Edge detect: evt = in_latch & ~latch_prev; latch_prev <= in_latch every cycle. in_cyctype_dir, in_addr and in_data are sampled in the evt cycle.
- Filter: hit = cfg_enable & (((in_addr[15:0] ^ cfg_addr_match) & cfg_addr_mask) == 0).
  - mask=0 accepts all.
  - evt without hit is ignored silently (no drop count).
- Push: on evt & hit, write {ovf, cyctype_dir, addr[15:0], data} (29 bits).
  - ovf = sticky drop flag; the flag clears on a successful push.
  - Push is accepted if fifo_count<DEPTH, or a pop occurs in the same cycle.
  - Otherwise the transaction is dropped: drop flag set, drop_count += 1, saturating at 255.
- Simultaneous push+pop: fifo_count unchanged.
- States: IDLE, SEND.
  - IDLE: if FIFO non-empty, pop head into the frame register, byte index=0, out_valid<=1, go to SEND.
  - SEND: out_byte is driven from the frame register by index.
    - byte0 = {cyctype_dir, 3'b000, ovf}
    - byte1 = addr[15:8]
    - byte2 = addr[7:0]
    - byte3 = data
  - Transfer occurs on out_valid & out_ready; index increments.
  - After the byte3 transfer:
    - if FIFO non-empty, pop the next entry the same cycle, stay in SEND, index=0, out_valid stays 1 (back-to-back frames, no gap);
    - else out_valid<=0, go to IDLE.
  - While out_valid & ~out_ready, out_byte and out_valid hold stable.
  - out_valid never deasserts without a transfer, except on reset.
- Latency: evt seen at edge k -> FIFO write at edge k -> pop at edge k+1 -> out_valid=1, byte0 after edge k+1. Minimum frame duration is 4 cycles with out_ready=1.
- cfg_enable=0 blocks new pushes only; queued entries and any frame in flight still drain.
- Config inputs are sampled per event; changes take effect on the next evt.
- busy = (state==SEND) | (fifo_count!=0).
- fifo_count reflects registered occupancy and excludes the entry held in the frame register.

Test Plan:
- Single write: reset, cyctype_dir=4'h2, addr=16'h0080, data=8'h5A, mask=0, out_ready=1, latch pulse -> out_valid rises 2 cycles after latch; bytes 0x20, 0x00, 0x80, 0x5A on consecutive cycles; then out_valid=0, busy=0.
- Filter: match=16'h0080, mask=16'hFFFF; events at 0x0080 and 0x0081 -> only the 0x0080 frame emitted; drop_count=0.
- Backpressure: out_ready=0 for 10 cycles mid-frame after byte1 -> out_byte holds 0x00 and out_valid stays 1; resume -> 0x80, 0x5A.
- Overflow: DEPTH=8, out_ready=0, 10 events with data 0..9 -> after the frame register takes event 0 and 8 entries are queued, event 9 is dropped:
  - fifo_count=8, drop_count=1;
  - with out_ready=1, the next accepted event's frame has byte0 bit0=1;
  - the earlier 9 frames have bit0=0;
  - no gaps between frames.
- Saturation/latch-at-reset: hold in_latch=1 across reset release -> no frame; force 300 drops -> drop_count=255.
- Reset mid-frame: assert lpc_reset after byte1 -> next cycle out_valid=0, fifo_count=0; a new event afterwards produces a complete fresh frame.
